// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and AXI-side signals for mem_port_arbiter.
// The arbiter takes the slave view; the requesters and AXI master take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int N_PORTS    = 3,
  parameter int IDX_W      = 2
);
  logic [N_PORTS-1:0]            req_strobe;
  logic [N_PORTS-1:0]            req_rw;
  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [N_PORTS*DATA_WIDTH-1:0] req_din;
  logic [N_PORTS-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [IDX_W-1:0]              grant_idx;
  logic                          busy;
  logic                          axi_done;
  logic [DATA_WIDTH-1:0]         axi_din;
  logic                          axi_strobe;
  logic                          axi_rw;
  logic [ADDR_WIDTH-1:0]         axi_addr;
  logic [DATA_WIDTH-1:0]         axi_dout;

  modport slave (
    input  req_strobe, req_rw, req_addr, req_din, axi_done, axi_din,
    output req_ready, rsp_data, grant_idx, busy, axi_strobe, axi_rw, axi_addr, axi_dout
  );

  modport master (
    output req_strobe, req_rw, req_addr, req_din, axi_done, axi_din,
    input  req_ready, rsp_data, grant_idx, busy, axi_strobe, axi_rw, axi_addr, axi_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of a single AXI master port, fixed-priority or round-robin.
// The winning request is latched at grant so requesters may change inputs once accepted.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int N_PORTS    = 3,
  parameter int RR_MODE    = 0,
  parameter int IDX_W      = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   any_req;
  logic                   win_rw;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_din;
  logic [N_PORTS-1:0]     grant_onehot;
  int                     cand;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    any_req      = 1'b0;
    win_idx      = '0;
    cand         = 0;
    grant_onehot = '0;
    // Search starts at rr_ptr in round-robin mode, at port 0 otherwise.
    for (int i = 0; i < N_PORTS; i++) begin
      cand = (RR_MODE != 0) ? (int'(rr_ptr) + i) % N_PORTS : i;
      if (!any_req && bus.req_strobe[cand]) begin
        any_req = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
    win_rw   = bus.req_rw[win_idx];
    win_addr = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_din  = win_rw ? bus.req_din[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    next_ptr = (int'(win_idx) == N_PORTS - 1) ? '0 : win_idx + IDX_W'(1);
    grant_onehot[bus.grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      bus.req_ready  <= '0;
      bus.rsp_data   <= '0;
      bus.grant_idx  <= '0;
      bus.busy       <= 1'b0;
      bus.axi_strobe <= 1'b0;
      bus.axi_rw     <= 1'b0;
      bus.axi_addr   <= '0;
      bus.axi_dout   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.grant_idx  <= win_idx;
            bus.busy       <= 1'b1;
            bus.axi_strobe <= 1'b1;
            bus.axi_rw     <= win_rw;
            bus.axi_addr   <= win_addr;
            bus.axi_dout   <= win_din;
            if (RR_MODE != 0) rr_ptr <= next_ptr;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.axi_done) begin
            bus.axi_strobe <= 1'b0;
            bus.axi_rw     <= 1'b0;
            bus.axi_addr   <= '0;
            bus.axi_dout   <= '0;
            bus.req_ready  <= grant_onehot;
            bus.rsp_data   <= bus.axi_rw ? '0 : bus.axi_din;
            state          <= DONE;
          end
        end
        DONE: begin
          // No arbitration here: a requester may drop its strobe during its ready cycle.
          bus.req_ready <= '0;
          bus.rsp_data  <= '0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives one fixed-priority and one round-robin arbiter with identical stimulus
// and compares both against a scoreboard of expected grants and transfers.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int NP = 3;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP-1:0]    req_strobe = '0;
  logic [NP-1:0]    req_rw = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_din = '0;
  logic           axi_done = 1'b0;
  logic [DW-1:0]  axi_din = '0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_PORTS(NP), .IDX_W(IW)) bus_fp ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_PORTS(NP), .IDX_W(IW)) bus_rr ();

  assign bus_fp.req_strobe = req_strobe;
  assign bus_fp.req_rw     = req_rw;
  assign bus_fp.req_addr   = req_addr;
  assign bus_fp.req_din    = req_din;
  assign bus_fp.axi_done   = axi_done;
  assign bus_fp.axi_din    = axi_din;
  assign bus_rr.req_strobe = req_strobe;
  assign bus_rr.req_rw     = req_rw;
  assign bus_rr.req_addr   = req_addr;
  assign bus_rr.req_din    = req_din;
  assign bus_rr.axi_done   = axi_done;
  assign bus_rr.axi_din    = axi_din;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_PORTS(NP), .RR_MODE(0), .IDX_W(IW))
    dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_PORTS(NP), .RR_MODE(1), .IDX_W(IW))
    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));

  typedef struct {
    int            idx;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic [DW-1:0] rsp;
  } exp_t;

  exp_t q_fp[$];
  exp_t q_rr[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rr_ptr   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fp_win(input logic [NP-1:0] s);
    for (int i = 0; i < NP; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic int rr_win(input logic [NP-1:0] s, input int p);
    for (int i = 0; i < NP; i++) if (s[(p + i) % NP]) return (p + i) % NP;
    return -1;
  endfunction

  function automatic exp_t model(input int w, input logic [DW-1:0] rd);
    exp_t e;
    e.idx  = w;
    e.rw   = req_rw[w];
    e.addr = req_addr[w*AW +: AW];
    e.dout = e.rw ? req_din[w*DW +: DW] : '0;
    e.rsp  = e.rw ? '0 : rd;
    return e;
  endfunction

  task automatic chk_busy(input string tag, input exp_t e, input logic [IW-1:0] gi, input logic strb,
                          input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic bsy);
    chk({tag, "_grant"}, gi, e.idx);
    chk({tag, "_strobe"}, strb, 1'b1);
    chk({tag, "_rw"}, rw, e.rw);
    chk({tag, "_addr"}, a, e.addr);
    chk({tag, "_dout"}, d, e.dout);
    chk({tag, "_busy"}, bsy, 1'b1);
  endtask

  task automatic chk_ready(input string tag, input exp_t e, input logic [NP-1:0] rdy, input logic [DW-1:0] rsp,
                           input logic strb, input logic [AW-1:0] a, input logic bsy);
    logic [NP-1:0] oh;
    oh = '0;
    oh[e.idx] = 1'b1;
    chk({tag, "_ready"}, rdy, oh);
    chk({tag, "_rsp"}, rsp, e.rsp);
    chk({tag, "_strobe_off"}, strb, 1'b0);
    chk({tag, "_addr_clr"}, a, '0);
    chk({tag, "_busy_done"}, bsy, 1'b1);
  endtask

  task automatic chk_idle(input string tag, input exp_t e, input logic [NP-1:0] rdy, input logic [DW-1:0] rsp,
                          input logic bsy, input logic [IW-1:0] gi);
    chk({tag, "_ready_off"}, rdy, '0);
    chk({tag, "_rsp_off"}, rsp, '0);
    chk({tag, "_busy_off"}, bsy, 1'b0);
    chk({tag, "_grant_hold"}, gi, e.idx);
  endtask

  // Caller drives strobes before the call; the next rising edge must grant.
  task automatic run_txn(input string tag, input int done_dly, input logic [DW-1:0] rd,
                         input bit release_w, input bit drop_early);
    exp_t ef;
    exp_t er;
    int   wr;
    wr = rr_win(req_strobe, rr_ptr);
    q_fp.push_back(model(fp_win(req_strobe), rd));
    q_rr.push_back(model(wr, rd));
    rr_ptr = (wr + 1) % NP;
    @(negedge clk);
    ef = q_fp.pop_front();
    er = q_rr.pop_front();
    chk_busy({tag, "_fp"}, ef, bus_fp.grant_idx, bus_fp.axi_strobe, bus_fp.axi_rw, bus_fp.axi_addr, bus_fp.axi_dout, bus_fp.busy);
    chk_busy({tag, "_rr"}, er, bus_rr.grant_idx, bus_rr.axi_strobe, bus_rr.axi_rw, bus_rr.axi_addr, bus_rr.axi_dout, bus_rr.busy);
    if (drop_early) begin
      req_strobe[ef.idx] = 1'b0;
      req_addr = ~req_addr;
      req_din  = ~req_din;
      req_rw   = ~req_rw;
    end
    for (int i = 1; i < done_dly; i++) begin
      @(negedge clk);
      chk_busy({tag, "_hold_fp"}, ef, bus_fp.grant_idx, bus_fp.axi_strobe, bus_fp.axi_rw, bus_fp.axi_addr, bus_fp.axi_dout, bus_fp.busy);
      chk_busy({tag, "_hold_rr"}, er, bus_rr.grant_idx, bus_rr.axi_strobe, bus_rr.axi_rw, bus_rr.axi_addr, bus_rr.axi_dout, bus_rr.busy);
    end
    axi_done = 1'b1;
    axi_din  = rd;
    @(negedge clk);
    axi_done = 1'b0;
    axi_din  = '0;
    chk_ready({tag, "_fp"}, ef, bus_fp.req_ready, bus_fp.rsp_data, bus_fp.axi_strobe, bus_fp.axi_addr, bus_fp.busy);
    chk_ready({tag, "_rr"}, er, bus_rr.req_ready, bus_rr.rsp_data, bus_rr.axi_strobe, bus_rr.axi_addr, bus_rr.busy);
    if (release_w) req_strobe[ef.idx] = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_fp"}, ef, bus_fp.req_ready, bus_fp.rsp_data, bus_fp.busy, bus_fp.grant_idx);
    chk_idle({tag, "_rr"}, er, bus_rr.req_ready, bus_rr.rsp_data, bus_rr.busy, bus_rr.grant_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [DW-1:0] beef;
    beef = {8{32'hDEAD_BEEF}};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobe_fp", bus_fp.axi_strobe, 1'b0);
    chk("rst_busy_fp", bus_fp.busy, 1'b0);
    chk("rst_ready_fp", bus_fp.req_ready, '0);
    chk("rst_grant_fp", bus_fp.grant_idx, '0);
    chk("rst_addr_fp", bus_fp.axi_addr, '0);
    chk("rst_rsp_fp", bus_fp.rsp_data, '0);
    chk("rst_strobe_rr", bus_rr.axi_strobe, 1'b0);
    chk("rst_busy_rr", bus_rr.busy, 1'b0);
    rst = 1'b0;

    // All three request, each drops after its ready: grants 0, 1, 2 in both modes
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AW +: AW] = 32'h1000_0000 + 32'(p) * 32'h40;
      req_din[p*DW +: DW]  = {8{$urandom()}};
    end
    req_rw     = 3'b101;
    req_strobe = 3'b111;
    for (int k = 0; k < NP; k++) run_txn($sformatf("all3_%0d", k), 4, {8{$urandom()}}, 1'b1, 1'b0);

    // Continuous requests: round-robin rotates, fixed priority keeps port 0
    req_strobe = 3'b111;
    for (int k = 0; k < 6; k++) run_txn($sformatf("cont_%0d", k), 2, {8{$urandom()}}, 1'b0, 1'b0);
    req_strobe = 3'b101;
    run_txn("p02_a", 2, {8{$urandom()}}, 1'b0, 1'b0);
    run_txn("p02_b", 2, {8{$urandom()}}, 1'b0, 1'b0);

    // Port 1 write
    req_strobe = 3'b010;
    req_rw     = 3'b010;
    req_addr[1*AW +: AW] = 32'h8000_0040;
    req_din[1*DW +: DW]  = {32{8'hA5}};
    run_txn("wr_p1", 3, beef, 1'b1, 1'b0);

    // Port 2 read returns axi_din for one cycle
    req_strobe = 3'b100;
    req_rw     = 3'b000;
    req_addr[2*AW +: AW] = 32'h0000_1F00;
    run_txn("rd_p2", 2, beef, 1'b1, 1'b0);

    // Port 0 drops strobe and changes inputs during BUSY
    req_strobe = 3'b001;
    req_rw     = 3'b000;
    req_addr[0*AW +: AW] = 32'h0000_2A40;
    run_txn("drop_p0", 4, {8{$urandom()}}, 1'b0, 1'b1);
    req_strobe = '0;
    req_rw     = '0;

    // Spurious axi_done in IDLE
    axi_done = 1'b1;
    @(negedge clk);
    axi_done = 1'b0;
    chk("spur_ready_fp", bus_fp.req_ready, '0);
    chk("spur_ready_rr", bus_rr.req_ready, '0);
    chk("spur_busy_fp", bus_fp.busy, 1'b0);
    chk("spur_strobe_rr", bus_rr.axi_strobe, 1'b0);
    @(negedge clk);
    chk("spur_ready2_fp", bus_fp.req_ready, '0);

    // Reset during BUSY aborts; round-robin pointer returns to 0
    req_strobe = 3'b010;
    @(negedge clk);
    chk("prerst_strobe_rr", bus_rr.axi_strobe, 1'b1);
    chk("prerst_grant_rr", bus_rr.grant_idx, 2'd1);
    req_strobe = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_strobe_fp", bus_fp.axi_strobe, 1'b0);
    chk("midrst_busy_fp", bus_fp.busy, 1'b0);
    chk("midrst_ready_fp", bus_fp.req_ready, '0);
    chk("midrst_strobe_rr", bus_rr.axi_strobe, 1'b0);
    chk("midrst_busy_rr", bus_rr.busy, 1'b0);
    chk("midrst_grant_rr", bus_rr.grant_idx, '0);
    @(negedge clk);
    chk("midrst_noready_rr", bus_rr.req_ready, '0);
    rr_ptr = 0;
    req_strobe = 3'b111;
    run_txn("post_rst", 2, {8{$urandom()}}, 1'b1, 1'b0);
    req_strobe = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
